// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer: arbitrates two SPI byte requests and runs the APB register sequence for each
module spi_apb_sequencer #(
  parameter logic [9:0] BASE_ADDR = 10'h001,
  parameter logic [7:0] CMD_START = 8'h01,
  parameter int         BUSY_BIT  = 0,
  parameter logic [7:0] POLL_MAX  = 8'd255
) (
  input  logic        i_PCLK,
  input  logic        i_PRESETn,
  input  logic [1:0]  i_req,
  input  logic [7:0]  i_cfg0,
  input  logic [7:0]  i_cfg1,
  input  logic [7:0]  i_tx0,
  input  logic [7:0]  i_tx1,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic [7:0]  o_rx,
  output logic        o_PSEL,
  output logic        o_PENABLE,
  output logic        o_PWRITE,
  output logic [15:0] o_PADDR,
  output logic [7:0]  o_PWDATA,
  input  logic [7:0]  i_PRDATA,
  input  logic        i_PREADY
);
  typedef enum logic [2:0] {IDLE, ARB, SETUP, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  poll_q, poll_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        err_q, err_d;
  logic [7:0]  cfg_q, cfg_d, tx_q, tx_d, rx_q, rx_d;
  logic        win, bus;
  logic [1:0]  win_oh;
  logic [3:0]  reg_idx;

  // State and datapath registers; the pointer resets to 1 so requester 0 wins the first tie
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q <= IDLE;
      step_q  <= '0;
      poll_q  <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      cfg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      poll_q  <= poll_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  // Next-state: arbitration, step sequencing, STATE polling with timeout
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    poll_d  = poll_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    cfg_d   = cfg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    win     = (i_req == 2'b11) ? ~ptr_q : i_req[1];
    win_oh  = win ? 2'b10 : 2'b01;
    case (state_q)
      IDLE: state_d = (|i_req) ? ARB : IDLE;
      ARB: begin
        state_d = (|i_req) ? SETUP : IDLE;
        if (|i_req) begin
          gnt_d  = win_oh;
          cfg_d  = win ? i_cfg1 : i_cfg0;
          tx_d   = win ? i_tx1 : i_tx0;
          step_d = '0;
          poll_d = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (i_PREADY) begin
        if (step_q < 3'd3) begin
          step_d  = step_q + 3'd1;
          state_d = SETUP;
        end else if (step_q == 3'd3) begin
          if (!i_PRDATA[BUSY_BIT]) begin
            step_d  = 3'd4;
            state_d = SETUP;
          end else if (poll_q == POLL_MAX - 8'd1) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            poll_d  = poll_q + 8'd1;
            state_d = SETUP;
          end
        end else begin
          rx_d    = i_PRDATA;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        ptr_d   = gnt_q[1];
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB and client outputs decoded from state and step; bus is all-zero outside a transfer
  always_comb begin
    bus       = (state_q == SETUP) || (state_q == ACCESS);
    reg_idx   = (step_q == 3'd1 || step_q == 3'd4) ? 4'd1 : (step_q == 3'd2) ? 4'd3 : 4'd0;
    o_PSEL    = bus;
    o_PENABLE = state_q == ACCESS;
    o_PWRITE  = bus && (step_q < 3'd3);
    o_PADDR   = bus ? {BASE_ADDR, reg_idx, 2'b00} : '0;
    o_PWDATA  = !bus ? '0 : (step_q == 3'd0) ? cfg_q : (step_q == 3'd1) ? tx_q :
                (step_q == 3'd2) ? CMD_START : '0;
    o_gnt     = (state_q == ARB) ? ((|i_req) ? win_oh : 2'b00) : gnt_q;
    o_done    = (state_q == DONE && !err_q) ? gnt_q : 2'b00;
    o_err     = (state_q == DONE && err_q) ? gnt_q : 2'b00;
    o_rx      = rx_q;
  end
endmodule

// File: tb/tb_spi_apb_sequencer.sv
// tb_spi_apb_sequencer: randomized checks of the APB sequencer against a transaction-level model
module tb_spi_apb_sequencer;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  req = 0;
  logic [7:0]  cfg0 = 0, cfg1 = 0, tx0 = 0, tx1 = 0;
  logic [1:0]  gnt, done, err;
  logic [7:0]  rx, pwdata;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [7:0]  prdata = 0;
  logic        pready = 0;

  typedef struct packed {logic w; logic [15:0] a; logic [7:0] d;} xfer_t;
  xfer_t log_q[$], exp_q[$];
  int busy_left = 0, wait_tx = 0, wait_left = 0;
  logic [7:0] rx_val = 0;
  int checks = 0, fails = 0;
  logic ptr_m = 1'b1;
  logic [7:0] last_rx = 0;

  localparam int PMAX = 4;

  always #5 clk = ~clk;

  spi_apb_sequencer #(.POLL_MAX(8'd4)) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n), .i_req(req),
    .i_cfg0(cfg0), .i_cfg1(cfg1), .i_tx0(tx0), .i_tx1(tx1),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_rx(rx),
    .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
    .o_PADDR(paddr), .o_PWDATA(pwdata), .i_PRDATA(prdata), .i_PREADY(pready)
  );

  // APB slave model: STATE busy for busy_left reads, wait states on the TX write, logs completed transfers
  always @(negedge clk) begin
    if (psel && !penable) begin
      pready = 0;
      wait_left = (pwrite && paddr == 16'h0044) ? wait_tx : 0;
    end else if (psel && penable) begin
      if (wait_left > 0) begin
        pready = 0;
        wait_left--;
      end else begin
        pready = 1;
        if (!pwrite) prdata = (paddr == 16'h0040) ? ((busy_left > 0) ? 8'h01 : 8'h00) : rx_val;
        if (!pwrite && paddr == 16'h0040 && busy_left > 0) busy_left--;
        log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
      end
    end else pready = 0;
  end

  task automatic run_req(input int idx, input logic [7:0] c, input logic [7:0] t,
                         input logic [7:0] r, input int busy, input int waits);
    int n, lat;
    bit got, exp_err;
    logic [1:0] oh;
    logic [15:0] sa;
    logic [7:0] sd;
    oh = 2'b01 << idx;
    log_q.delete();
    exp_q.delete();
    busy_left = busy;
    wait_tx = waits;
    rx_val = r;
    exp_err = busy >= PMAX;
    exp_q.push_back({1'b1, 16'h0040, c});
    exp_q.push_back({1'b1, 16'h0044, t});
    exp_q.push_back({1'b1, 16'h004C, 8'h01});
    if (exp_err) repeat (PMAX) exp_q.push_back({1'b0, 16'h0040, 8'h01});
    else begin
      repeat (busy) exp_q.push_back({1'b0, 16'h0040, 8'h01});
      exp_q.push_back({1'b0, 16'h0040, 8'h00});
      exp_q.push_back({1'b0, 16'h0044, r});
    end
    lat = exp_err ? 8 + 2 * PMAX + waits : 12 + 2 * busy + waits;
    if (idx == 0) begin cfg0 = c; tx0 = t; end else begin cfg1 = c; tx1 = t; end
    req[idx] = 1'b1;
    n = 0; got = 0; sa = 0; sd = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        cfg0 = 8'($urandom); cfg1 = 8'($urandom); tx0 = 8'($urandom); tx1 = 8'($urandom);
      end
      if (psel && !penable) begin
        sa = paddr; sd = pwdata;
      end else if (psel && penable) begin
        checks++;
        if (paddr !== sa || pwdata !== sd) begin
          fails++;
          $display("FAIL apb_stable addr %h data %h, setup had %h %h", paddr, pwdata, sa, sd);
        end
      end
      got = (|done) || (|err);
    end
    checks++;
    if (!got) begin fails++; $display("FAIL completion_timeout after %0d cycles", n); end
    checks++;
    if (n != lat) begin fails++; $display("FAIL latency got %0d want %0d", n, lat); end
    checks++;
    if (done !== (exp_err ? 2'b00 : oh)) begin fails++; $display("FAIL done got %b want %b", done, exp_err ? 2'b00 : oh); end
    checks++;
    if (err !== (exp_err ? oh : 2'b00)) begin fails++; $display("FAIL err got %b want %b", err, exp_err ? oh : 2'b00); end
    checks++;
    if (gnt !== oh) begin fails++; $display("FAIL gnt_at_done got %b want %b", gnt, oh); end
    checks++;
    if (rx !== (exp_err ? last_rx : r)) begin fails++; $display("FAIL rx got %h want %h", rx, exp_err ? last_rx : r); end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL xfer_count got %0d want %0d", log_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin fails++; $display("FAIL xfer%0d got %h want %h", i, log_q[i], exp_q[i]); end
    end
    ptr_m = idx[0];
    if (!exp_err) last_rx = r;
    req[idx] = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
      fails++;
      $display("FAIL after_done gnt %b done %b err %b, want all 0", gnt, done, err);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata} !== 41'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", {gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata});
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata} !== 41'd0) begin
      fails++;
      $display("FAIL idle_outputs got %h want 0", {gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata});
    end
  endtask

  task automatic test_basic();
    run_req(0, 8'h3C, 8'hA5, 8'h5A, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++)
      run_req($urandom_range(1, 0), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(2, 0), $urandom_range(2, 0));
  endtask

  task automatic test_busy();
    run_req($urandom_range(1, 0), 8'($urandom), 8'($urandom), 8'($urandom), 3, 0);
  endtask

  task automatic test_timeout();
    run_req($urandom_range(1, 0), 8'($urandom), 8'($urandom), 8'($urandom), 10, 0);
  endtask

  task automatic test_wait();
    run_req($urandom_range(1, 0), 8'($urandom), 8'($urandom), 8'($urandom), 0, 3);
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    logic w;
    logic [1:0] oh;
    busy_left = 0; wait_tx = 0; rx_val = 8'($urandom);
    cfg0 = 8'($urandom); cfg1 = 8'($urandom);
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      w = ~ptr_m;
      oh = w ? 2'b10 : 2'b01;
      n = 0; got = 0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (k > 0 && n == 1) begin
          checks++;
          if (done !== 2'b00) begin fails++; $display("FAIL done_pulse_width got %b want 00", done); end
        end
        if (n == (k == 0 ? 1 : 2)) begin
          checks++;
          if (gnt !== oh) begin fails++; $display("FAIL b2b_grant%0d got %b want %b", k, gnt, oh); end
        end
        got = (|done) || (|err);
      end
      checks++;
      if (n != (k == 0 ? 12 : 13)) begin fails++; $display("FAIL b2b_spacing%0d got %0d want %0d", k, n, k == 0 ? 12 : 13); end
      checks++;
      if (done !== oh || err !== 2'b00) begin fails++; $display("FAIL b2b_done%0d got %b/%b want %b/00", k, done, err, oh); end
      checks++;
      if (rx !== rx_val) begin fails++; $display("FAIL b2b_rx%0d got %h want %h", k, rx, rx_val); end
      ptr_m = w;
      last_rx = rx_val;
      if (k == 2) req = 2'b00;
    end
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || gnt !== 2'b00) begin fails++; $display("FAIL b2b_end done %b gnt %b want 00", done, gnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit, stray;
    busy_left = 0; wait_tx = 0; rx_val = 8'($urandom);
    req = 2'b01;
    n = 0; hit = 0;
    while (!hit && n < 50) begin
      @(negedge clk);
      n++;
      hit = psel && penable && paddr == 16'h004C;
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL cmd_access_seen got 0 want 1"); end
    rst_n = 0;
    #1;
    checks++;
    if ({gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata} !== 41'd0) begin
      fails++;
      $display("FAIL async_reset_outputs got %h want 0", {gnt, done, err, rx, psel, penable, pwrite, paddr, pwdata});
    end
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1;
    ptr_m = 1'b1;
    last_rx = 8'h00;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (|done || |err || psel) stray = 1;
    end
    checks++;
    if (stray) begin fails++; $display("FAIL no_done_after_reset got activity want none"); end
    run_req(1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_busy();
    test_timeout();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_apb_sequencer.md
# spi_apb_sequencer

APB master that runs complete SPI byte transfers on the SPI peripheral's APB register port on behalf of two requesters. Each request is a CONFIG byte plus a TX byte. A round-robin arbiter grants one requester. The block then issues the APB sequence: write CONFIG, write TX, write CMD start, poll STATE until not busy, read RX. It returns the received byte with a done/error pulse. It sits between on-chip clients and the peripheral's APB decoder (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY).

## Interface
- BASE_ADDR, 10'h001, compared against PADDR[15:6]
- CMD_START, 8'h01, byte written to CMD register to launch a transfer
- BUSY_BIT, 0, bit index of the busy flag in STATE
- POLL_MAX, 8'd255, maximum STATE reads before timeout
- i_PCLK  in  1  clock; all logic on rising edge
- i_PRESETn  in  1  reset, asynchronous, active-low
- i_req  in  2  request per requester; held high until o_done/o_err pulse for that requester
- i_cfg0, i_cfg1  in  8  CONFIG byte of requester 0/1
- i_tx0, i_tx1  in  8  TX byte of requester 0/1
- o_gnt  out  2  one-hot grant, high from grant until end of DONE
- o_done  out  2  1-cycle completion pulse, indexed by requester
- o_err  out  2  1-cycle timeout pulse, indexed by requester
- o_rx  out  8  received byte, valid with o_done, held until next completion
- o_PSEL  out  1  APB select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PADDR  out  16  {BASE_ADDR, reg[3:0], 2'b00}
- o_PWDATA  out  8  write data
- i_PRDATA  in  8  read data
- i_PREADY  in  1  transfer complete in access phase

## Operation
- Register map, reg index: CONFIG 0 (write), TX 1 (write), CMD 3 (write), STATE 0 (read), RX 1 (read).
- FSM states: IDLE, ARB, SETUP, ACCESS, DONE. A 3-bit step register selects the operation: 0 WR_CFG, 1 WR_TX, 2 WR_CMD, 3 RD_STATE, 4 RD_RX.
- IDLE: if any i_req is set, go to ARB.
- ARB: grant by round-robin. The last-granted pointer starts at 1 after reset, so requester 0 wins the first tie. On a tie, the requester other than the pointer wins. Latch the winner's cfg/tx bytes. Set o_gnt, step=0, poll count=0. Go to SETUP.
- SETUP: o_PSEL=1, o_PENABLE=0. Drive PADDR, PWRITE and PWDATA for the step. Go to ACCESS.
- ACCESS: o_PSEL=1, o_PENABLE=1 with address and data held stable. Remain until i_PREADY=1. On i_PREADY:
  - steps 0-2: step+1, go to SETUP.
  - step 3: if i_PRDATA[BUSY_BIT]=0, step=4, go to SETUP. Otherwise, if poll count = POLL_MAX-1, set the error flag and go to DONE; else increment poll count and go to SETUP (step stays 3).
  - step 4: capture i_PRDATA into o_rx, go to DONE.
- DONE: pulse o_done[g] (or o_err[g] if the error flag is set). Clear the error flag, update the pointer to g, drop o_gnt. Go to IDLE.
- Idle bus values: o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0.
- The latched cfg/tx bytes are immune to requester input changes after ARB.
- A requester deasserting i_req mid-sequence is ignored; the sequence completes.
- The requester just served cannot be granted again from the same DONE. The earliest re-grant is the ARB that follows the next IDLE.

## Timing
- Reset (asynchronous, any state): state=IDLE, step=0, pointer=1. All outputs are 0: o_gnt, o_done, o_err, o_rx, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA.
- Reset asserted mid-transfer drops PSEL/PENABLE immediately. The interrupted requester receives no done/err.
- Each APB transfer takes 2 cycles with zero-wait PREADY, plus one cycle per wait state.
- Zero-wait, one poll: i_req rises at cycle 0 (sampled edge 1). ARB at cycle 1, first SETUP at cycle 2, DONE at cycle 12. o_done is high during cycle 12; o_gnt falls after cycle 12.
- Each additional busy poll adds 2 cycles.
- o_rx changes only in the DONE entry edge; it keeps its value on error.
- Back-to-back: with both requests held, the second grant appears 2 cycles after the first o_done (IDLE, then ARB).

## Test plan
- Reset, then i_req=2'b01, cfg0=8'h3C, tx0=8'hA5, STATE=8'h00, RX=8'h5A: APB writes in order (0x0040, 3C), (0x0044, A5), (0x004C, 01). Then reads at 0x0040 and 0x0044. o_done=2'b01 at cycle 12 with o_rx=8'h5A.
- Both requests held continuously: grants alternate 01, 10, 01. Each o_done pulse is 1 cycle and matches the granted index.
- STATE returns busy (8'h01) for 3 reads, then 8'h00: exactly 4 STATE reads; o_done arrives 6 cycles later than the one-poll case.
- STATE stuck at 8'h01 with POLL_MAX=4: exactly 4 STATE reads, then an o_err pulse. No RX read; o_rx unchanged.
- i_PREADY held low for 3 cycles during the TX write: PADDR/PWDATA/PENABLE stay stable throughout. Completion shifts by 3 cycles.
- i_PRESETn pulsed low during the CMD-write ACCESS: all outputs are 0 asynchronously. After release there is no done. A new request completes normally.
